systolic_result_drain: RTL and testbench

Downstream drain stage for the 3x3 systolic array multiplier. After a `start` pulse it waits a fixed number of cycles for the nine 64-bit MAC accumulators to settle. It then snapshots all nine results at once and streams them out one per handshake, in row-major order, over a valid/ready interface. This decouples the array's free-running outputs from a slower consumer such as a bus writer or UART packer.

---
 rtl/systolic_result_drain_if.sv | 27 ++
 rtl/systolic_result_drain.sv | 138 +++++++++++++
 tb/tb_systolic_result_drain.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// Result stream between the drain stage and its consumer: one word per
// valid/ready handshake, tagged with its row-major index and a last flag.
interface systolic_result_drain_if #(
   parameter int DATA_W = 64
);
   logic [DATA_W-1:0] res_data;
   logic              res_valid;
   logic              res_ready;
   logic [3:0]        res_index;
   logic              res_last;

   modport master (
      output res_data,
      output res_valid,
      output res_index,
      output res_last,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_valid,
      input  res_index,
      input  res_last,
      output res_ready
   );
endinterface

// File: rtl/systolic_result_drain.sv
// Drain stage for the 3x3 systolic array: waits LATENCY edges after start, snapshots
// the nine accumulators, then streams them out row-major over a valid/ready port.
module systolic_result_drain #(
   parameter int LATENCY = 12,
   parameter int DATA_W  = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [DATA_W-1:0]    adder_out1_i,
   input  logic [DATA_W-1:0]    adder_out2_i,
   input  logic [DATA_W-1:0]    adder_out3_i,
   input  logic [DATA_W-1:0]    adder_out4_i,
   input  logic [DATA_W-1:0]    adder_out5_i,
   input  logic [DATA_W-1:0]    adder_out6_i,
   input  logic [DATA_W-1:0]    adder_out7_i,
   input  logic [DATA_W-1:0]    adder_out8_i,
   input  logic [DATA_W-1:0]    adder_out9_i,
   systolic_result_drain_if.master res_if,
   output logic                 busy_o,
   output logic                 start_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] LAT_M1   = 8'(LATENCY - 1);
   localparam logic [3:0] LAST_IDX = 4'd8;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic              start_err_q, start_err_d;
   logic              snap_load;
   logic              drain_w;
   logic              hs_w;
   logic              final_hs_w;
   logic [DATA_W-1:0] adder_w [9];
   logic [DATA_W-1:0] snap_q  [9];

   assign adder_w[0] = adder_out1_i;
   assign adder_w[1] = adder_out2_i;
   assign adder_w[2] = adder_out3_i;
   assign adder_w[3] = adder_out4_i;
   assign adder_w[4] = adder_out5_i;
   assign adder_w[5] = adder_out6_i;
   assign adder_w[6] = adder_out7_i;
   assign adder_w[7] = adder_out8_i;
   assign adder_w[8] = adder_out9_i;

   assign drain_w    = (state_q == ST_DRAIN);
   assign hs_w       = drain_w && res_if.res_ready;
   assign final_hs_w = hs_w && (idx_q == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         start_err_q <= start_err_d;
      end
   end

   // The whole bank is captured on one edge so the drained words form a coherent set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) begin
            snap_q[i] <= '0;
         end
      end else if (snap_load) begin
         for (int i = 0; i < 9; i++) begin
            snap_q[i] <= adder_w[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      start_err_d = 1'b0;
      snap_load   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_WAIT;
               cnt_d   = LAT_M1;
            end
         end
         ST_WAIT: begin
            start_err_d = start_i;
            if (cnt_q == 8'd0) begin
               snap_load = 1'b1;
               idx_d     = '0;
               state_d   = ST_DRAIN;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_DRAIN: begin
            // A start coinciding with the last handshake chains a new window with no gap.
            if (final_hs_w) begin
               idx_d = '0;
               if (start_i) begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               start_err_d = start_i;
               if (hs_w) begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign res_if.res_valid = drain_w;
   assign res_if.res_index = idx_q;
   assign res_if.res_last  = drain_w && (idx_q == LAST_IDX);
   assign res_if.res_data  = drain_w ? snap_q[idx_q] : '0;
   assign busy_o           = (state_q != ST_IDLE);
   assign start_err_o      = start_err_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Drives a LATENCY=4 and a LATENCY=1 drain stage from shared stimulus and compares
// both against a timeline model of start/snapshot/handshake events.
module tb_systolic_result_drain;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        ready = 1'b0;
   logic [63:0] adder [9];

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int hs_cnt = 0;

   systolic_result_drain_if #(.DATA_W(64)) bus0 ();
   systolic_result_drain_if #(.DATA_W(64)) bus1 ();
   assign bus0.res_ready = ready;
   assign bus1.res_ready = ready;

   logic busy0, busy1, err0, err1;

   systolic_result_drain #(.LATENCY(4), .DATA_W(64)) u_l4 (
      .clk(clk), .rst(rst), .start_i(start),
      .adder_out1_i(adder[0]), .adder_out2_i(adder[1]), .adder_out3_i(adder[2]),
      .adder_out4_i(adder[3]), .adder_out5_i(adder[4]), .adder_out6_i(adder[5]),
      .adder_out7_i(adder[6]), .adder_out8_i(adder[7]), .adder_out9_i(adder[8]),
      .res_if(bus0.master), .busy_o(busy0), .start_err_o(err0)
   );

   systolic_result_drain #(.LATENCY(1), .DATA_W(64)) u_l1 (
      .clk(clk), .rst(rst), .start_i(start),
      .adder_out1_i(adder[0]), .adder_out2_i(adder[1]), .adder_out3_i(adder[2]),
      .adder_out4_i(adder[3]), .adder_out5_i(adder[4]), .adder_out6_i(adder[5]),
      .adder_out7_i(adder[6]), .adder_out8_i(adder[7]), .adder_out9_i(adder[8]),
      .res_if(bus1.master), .busy_o(busy1), .start_err_o(err1)
   );

   logic [63:0] obs_data  [2];
   logic        obs_valid [2];
   logic [3:0]  obs_index [2];
   logic        obs_last  [2];
   logic        obs_busy  [2];
   logic        obs_err   [2];

   always_comb begin
      obs_data[0]  = bus0.res_data;   obs_data[1]  = bus1.res_data;
      obs_valid[0] = bus0.res_valid;  obs_valid[1] = bus1.res_valid;
      obs_index[0] = bus0.res_index;  obs_index[1] = bus1.res_index;
      obs_last[0]  = bus0.res_last;   obs_last[1]  = bus1.res_last;
      obs_busy[0]  = busy0;           obs_busy[1]  = busy1;
      obs_err[0]   = err0;            obs_err[1]   = err1;
   end

   always #5 clk = ~clk;

   // Reference model: a window is the absolute edge of its snapshot plus a count of
   // words already handed over.
   bit          m_active    [2];
   int          m_snap_edge [2];
   int          m_words     [2];
   bit          m_err       [2];
   logic [63:0] m_snap      [2][9];

   function automatic int lat(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_active[d] = 1'b0;
         m_err[d]    = 1'b0;
         m_words[d]  = 0;
      end
   endtask

   task automatic model_edge();
      edge_n++;
      if (bus0.res_valid && ready) hs_cnt++;
      if (rst) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         bit drain, hs, fin, accept;
         drain  = m_active[d] && ((edge_n - 1) >= m_snap_edge[d]);
         hs     = drain && ready;
         fin    = hs && (m_words[d] == 8);
         accept = start && (!m_active[d] || fin);
         m_err[d] = start && m_active[d] && !fin;
         if (hs) m_words[d]++;
         if (fin) m_active[d] = 1'b0;
         if (accept) begin
            m_active[d]    = 1'b1;
            m_snap_edge[d] = edge_n + lat(d);
            m_words[d]     = 0;
         end
         if (m_active[d] && (edge_n == m_snap_edge[d])) begin
            for (int j = 0; j < 9; j++) m_snap[d][j] = adder[j];
         end
      end
   endtask

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         string pfx;
         bit    ev;
         pfx = (d == 0) ? "L4" : "L1";
         ev  = m_active[d] && (edge_n >= m_snap_edge[d]);
         check({pfx, "_valid"}, 64'(obs_valid[d]), 64'(ev));
         check({pfx, "_busy"}, 64'(obs_busy[d]), 64'(m_active[d]));
         check({pfx, "_start_err"}, 64'(obs_err[d]), 64'(m_err[d]));
         check({pfx, "_last"}, 64'(obs_last[d]), 64'(ev && (m_words[d] == 8)));
         if (ev) begin
            check({pfx, "_data"}, obs_data[d], m_snap[d][m_words[d]]);
            check({pfx, "_index"}, 64'(obs_index[d]), 64'(m_words[d]));
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_pattern();
      for (int j = 0; j < 9; j++) adder[j] = 64'(j + 1) * 64'h0000_0001_0000_0001;
   endtask

   task automatic set_random();
      for (int j = 0; j < 9; j++) adder[j] = {$urandom, $urandom};
   endtask

   task automatic check_zero_outputs(string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_valid"}, 64'(obs_valid[d]), 64'd0);
         check({tag, "_busy"}, 64'(obs_busy[d]), 64'd0);
         check({tag, "_err"}, 64'(obs_err[d]), 64'd0);
         check({tag, "_last"}, 64'(obs_last[d]), 64'd0);
         check({tag, "_index"}, 64'(obs_index[d]), 64'd0);
         check({tag, "_data"}, obs_data[d], 64'd0);
      end
   endtask

   logic [63:0] second_first;

   initial begin
      set_pattern();
      model_reset();
      #2 rst = 1'b1;
      #1 check_zero_outputs("reset");
      ticks(2);
      rst = 1'b0;
      ticks(2);

      // Basic drain
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("basic_busy_at_k", 64'(busy0), 64'd1);
      check("l1_valid_at_k", 64'(bus1.res_valid), 64'd0);
      tick();
      check("l1_valid_at_k1", 64'(bus1.res_valid), 64'd1);
      ticks(3);
      check("basic_first_word", bus0.res_data, 64'h0000_0001_0000_0001);
      check("basic_first_index", 64'(bus0.res_index), 64'd0);
      ticks(8);
      check("basic_last_word", bus0.res_data, 64'h0000_0009_0000_0009);
      check("basic_last_flag", 64'(bus0.res_last), 64'd1);
      tick();
      check("basic_idle_after", 64'(busy0), 64'd0);
      ticks(3);

      // Snapshot isolation
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(4);
      for (int j = 0; j < 9; j++) adder[j] = 64'hFFFF_FFFF_FFFF_FFFF;
      ticks(8);
      check("iso_last_word", bus0.res_data, 64'h0000_0009_0000_0009);
      ticks(3);
      set_pattern();

      // Backpressure at index 3
      hs_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(7);
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_data", bus0.res_data, 64'h0000_0004_0000_0004);
         check("bp_index", 64'(bus0.res_index), 64'd3);
      end
      ready = 1'b1;
      ticks(8);
      check("bp_word_count", 64'(hs_cnt), 64'd9);
      ticks(2);

      // Start collisions in WAIT and in DRAIN at index 2
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("coll_wait_err", 64'(err0), 64'd1);
      tick();
      check("coll_wait_err_clear", 64'(err0), 64'd0);
      tick();
      check("coll_valid_on_time", 64'(bus0.res_valid), 64'd1);
      ticks(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("coll_drain_err", 64'(err0), 64'd1);
      check("coll_drain_index", 64'(bus0.res_index), 64'd3);
      ticks(7);
      check("coll_idle_after", 64'(busy0), 64'd0);
      ticks(3);

      // Back-to-back windows
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(12);
      check("b2b_at_last", 64'(bus0.res_last), 64'd1);
      set_random();
      second_first = adder[0];
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_no_err", 64'(err0), 64'd0);
      check("b2b_busy", 64'(busy0), 64'd1);
      ticks(3);
      check("b2b_wait_no_valid", 64'(bus0.res_valid), 64'd0);
      tick();
      check("b2b_second_valid", 64'(bus0.res_valid), 64'd1);
      check("b2b_second_word", bus0.res_data, second_first);
      ticks(12);

      // Asynchronous reset mid-drain
      set_pattern();
      start = 1'b1;
      tick();
      start = 1'b0;
      ticks(9);
      check("rst_pre_index", 64'(bus0.res_index), 64'd5);
      #2 rst = 1'b1;
      model_reset();
      #1 check_zero_outputs("midrst");
      rst = 1'b0;
      ticks(12);
      check("midrst_no_resume", 64'(bus0.res_valid), 64'd0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 7) == 0);
         ready = ($urandom_range(0, 3) != 0);
         set_random();
         tick();
      end
      start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
